// File: rtl/axis_frame_limit.sv
// axis_frame_limit: enforces a run-time maximum AXI-Stream frame length, truncating oversize frames.
// Define AXIS_FRAME_LIMIT_STATUS_EN to implement status_frame_len / status_frame_len_valid.
module axis_frame_limit #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1,
    parameter int LEN_WIDTH = 16,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic [LEN_WIDTH-1:0]  length_max,
    output logic                  status_frame_truncated,
    output logic [LEN_WIDTH-1:0]  status_frame_len,
    output logic                  status_frame_len_valid
);
    typedef enum logic {PASS, DROP} state_t;
    state_t state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d, lim_q, lim, sat;
    logic [LEN_WIDTH:0] bytes, sum;
    logic first_q, first_d, ready_q, ready_d, tready_q, tready_d;
    logic acc, fwd, over, in_last, trunc_q;
    logic [USER_WIDTH-1:0] in_user;
    logic m_valid_q, m_valid_d, sk_valid_q, sk_valid_d;
    logic store_out, store_skid, skid_to_out;
    logic [DATA_WIDTH-1:0] m_data_q, sk_data_q;
    logic [KEEP_WIDTH-1:0] m_keep_q, sk_keep_q;
    logic m_last_q, sk_last_q;
    logic [USER_WIDTH-1:0] m_user_q, sk_user_q;

    always_comb begin
        bytes = '0;
        for (int i = 0; i < KEEP_WIDTH; i++)
            bytes = bytes + ((KEEP_ENABLE != 0) ? (LEN_WIDTH+1)'(s_axis_tkeep[i]) : (LEN_WIDTH+1)'(1));
        sum = {1'b0, cnt_q} + bytes;
        sat = sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
        // the limit is sampled on a frame's first beat and held for the rest of it
        lim = first_q ? length_max : lim_q;
        acc = s_axis_tvalid && tready_q;
        fwd = acc && state_q == PASS;
        over = lim != '0 && sum > {1'b0, lim};
        in_last = s_axis_tlast || over;
        in_user = over ? USER_BAD_FRAME_VALUE : s_axis_tuser;
        state_d = (fwd && over && !s_axis_tlast) ? DROP : (acc && s_axis_tlast) ? PASS : state_q;
        cnt_d = (acc && s_axis_tlast) ? '0 : fwd ? sat : cnt_q;
        first_d = acc ? s_axis_tlast : first_q;
        m_valid_d = m_valid_q;
        sk_valid_d = sk_valid_q;
        store_out = 1'b0;
        store_skid = 1'b0;
        skid_to_out = 1'b0;
        if (ready_q) begin
            if (m_axis_tready || !m_valid_q) begin
                m_valid_d = fwd;
                store_out = 1'b1;
            end else begin
                sk_valid_d = fwd;
                store_skid = 1'b1;
            end
        end else if (m_axis_tready) begin
            m_valid_d = sk_valid_q;
            sk_valid_d = 1'b0;
            skid_to_out = 1'b1;
        end
        // raw tvalid keeps the skid-empty guarantee whenever ready_q is high
        ready_d = m_axis_tready || (!sk_valid_q && (!m_valid_q || !s_axis_tvalid));
        tready_d = ready_d || state_d == DROP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PASS;
            cnt_q <= '0;
            lim_q <= '0;
            first_q <= 1'b1;
            ready_q <= 1'b0;
            tready_q <= 1'b0;
            m_valid_q <= 1'b0;
            sk_valid_q <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            lim_q <= lim;
            first_q <= first_d;
            ready_q <= ready_d;
            tready_q <= tready_d;
            m_valid_q <= m_valid_d;
            sk_valid_q <= sk_valid_d;
            trunc_q <= fwd && over;
        end
    end

    always_ff @(posedge clk) begin
        if (store_out) begin
            m_data_q <= s_axis_tdata;
            m_keep_q <= s_axis_tkeep;
            m_last_q <= in_last;
            m_user_q <= in_user;
        end else if (skid_to_out) begin
            m_data_q <= sk_data_q;
            m_keep_q <= sk_keep_q;
            m_last_q <= sk_last_q;
            m_user_q <= sk_user_q;
        end
        if (store_skid) begin
            sk_data_q <= s_axis_tdata;
            sk_keep_q <= s_axis_tkeep;
            sk_last_q <= in_last;
            sk_user_q <= in_user;
        end
    end

`ifdef AXIS_FRAME_LIMIT_STATUS_EN
    logic [LEN_WIDTH-1:0] len_q;
    logic len_valid_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            len_valid_q <= 1'b0;
        end else begin
            len_valid_q <= fwd && in_last;
            if (fwd && in_last)
                len_q <= sat;
        end
    end
    assign status_frame_len = len_q;
    assign status_frame_len_valid = len_valid_q;
`else
    assign status_frame_len = '0;
    assign status_frame_len_valid = 1'b0;
`endif

    assign s_axis_tready = tready_q;
    assign m_axis_tdata = m_data_q;
    assign m_axis_tkeep = m_keep_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast = m_last_q;
    assign m_axis_tuser = m_user_q;
    assign status_frame_truncated = trunc_q;
endmodule

// File: doc/axis_frame_limit.md
# axis_frame_limit

Upstream ingress stage for the AXI-Stream frame FIFO. It enforces a run-time maximum frame length in bytes and passes conforming frames unchanged. An oversize frame is truncated at the beat that crosses the limit: that beat goes out with tlast forced and tuser set to the bad-frame value, and the rest of the input frame is discarded. A FIFO built with DROP_BAD_FRAME then drops the truncated frame whole. Output is fully registered through a two-entry skid buffer for full throughput.

## Interface
Reset: one clock; reset is asynchronous and active-low.

Parameters:
- DATA_WIDTH, 8: tdata width in bits.
- KEEP_ENABLE, DATA_WIDTH>8: tkeep used for byte counting; when 0, every beat counts KEEP_WIDTH bytes.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width.
- USER_WIDTH, 1: tuser width.
- LEN_WIDTH, 16: byte-count and limit width.
- USER_BAD_FRAME_VALUE, 1'b1: tuser value driven on a truncating beat.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  DATA_WIDTH/KEEP_WIDTH/1/1/1/USER_WIDTH  input stream.
- m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  same widths  output stream.
- length_max  in  LEN_WIDTH  maximum frame bytes; 0 = unlimited.
- status_frame_truncated  out  1  one-cycle pulse per truncated frame.
- status_frame_len  out  LEN_WIDTH  bytes forwarded in the last completed frame.
- status_frame_len_valid  out  1  one-cycle pulse when status_frame_len updates.

## Operation
- Input beat accepted on s_axis_tvalid && s_axis_tready.
- Beat bytes: popcount(tkeep) when KEEP_ENABLE, else KEEP_WIDTH.
- Byte counter:
  - Holds bytes accepted so far in the current input frame.
  - Sum is computed at LEN_WIDTH+1 bits and saturates at all-ones.
  - Cleared after any input beat with tlast.
- length_max is latched on the first beat of each frame; changes mid-frame take effect on the next frame.
- State PASS, the reset state. On each accepted beat:
  - If limit≠0 and counter+bytes > limit: forward the beat with tlast=1 and tuser=USER_BAD_FRAME_VALUE, keep tkeep/tdata unchanged, pulse truncated.
    - If input tlast=1 on that beat, stay in PASS.
    - Otherwise go to DROP.
  - Else: forward the beat unchanged.
- State DROP:
  - s_axis_tready=1 regardless of output space.
  - Accepted beats are discarded and not counted.
  - Input tlast returns the state to PASS.
- On every forwarded tlast beat: status_frame_len = bytes forwarded including that beat; pulse status_frame_len_valid.
- Single-beat frame exceeding the limit: forwarded with tuser bad, one truncated pulse.

## Timing
- Latency: 1 cycle from input acceptance to m_axis_tvalid.
- s_axis_tready is registered. In PASS it is high when the skid entry is empty; it deasserts the cycle after the output stalls with the skid occupied.
- Sustains 1 beat/cycle with m_axis_tready held high. No beat lost or duplicated under arbitrary backpressure.
- m_axis outputs are stable while tvalid && !tready.
- Status pulses are asserted the cycle after the causing input beat is accepted.
- Reset values (also forced immediately on rst_n low):
  - m_axis_tvalid=0, s_axis_tready=0 during reset, 1 the first cycle after release.
  - Counter=0, state=PASS, status pulses=0, status_frame_len=0.
  - Data registers are don't-care.
- Reset mid-frame: the partial frame is lost. The next input beat starts a new frame with counter=0.

## Configuration
- AXIS_FRAME_LIMIT_STATUS_EN defined: status_frame_len and status_frame_len_valid are implemented as above.
- Not defined: both outputs are tied to 0 and the forwarded-byte accumulator is omitted. status_frame_truncated and the truncation behaviour are unaffected.

## Test plan
All scenarios: DATA_WIDTH=32, KEEP_WIDTH=4, length_max=10.
- Beats with keep 1111, 1111, 0011 (tlast) → identical output, tuser=0, status_frame_len=10, no truncated pulse.
- Four full beats (16 bytes) → three beats out, the third with tlast=1 and tuser=1; fourth beat accepted and discarded; one truncated pulse; status_frame_len=12.
- 50-frame random traffic, random m_axis_tready duty 30% → output matches reference model beat-for-beat; full rate when tready=1.
- rst_n low after beat 2 of a 3-beat frame → m_axis_tvalid=0 immediately; next frame of 2 beats passes clean with status_frame_len=8.
- length_max=0 with a 1000-byte frame → all 250 beats pass, no truncation. Then length_max changed to 4 mid-frame → applied only from the next frame.
- Single beat keep 1111, tlast, length_max=3 → one beat out with tuser=1, truncated pulse, state remains PASS.
